// File: rtl/wb_dec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : wb_dec_ctrl
// Brief    : Wishbone classic slave front end for a one-hot register decoder.
//            Optional macro WB_DEC_CTRL_ERR_EN turns unmapped accesses into
//            wb_err_o responses instead of zero-data acks.
// Revision : 1.0 - initial release
// ============================================================================
module wb_dec_ctrl #(
    parameter int RD_WAIT = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] dec_addr_o,
    input  logic [15:0] dec_sel_i,
    input  logic [31:0] dec_data_i,
    output logic [15:0] reg_wr_o,
    output logic [31:0] reg_wdata_o,
    output logic [15:0] err_cnt_o,
    output logic        busy_o
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_decode = 2'd1;
    localparam logic [1:0] c_wait   = 2'd2;
    localparam logic [1:0] c_ack    = 2'd3;

    // Counter reload; the RD_WAIT==0 case never enters WAIT.
    localparam logic [3:0] c_wait_load = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);

    logic [1:0]  r_state;
    logic        r_we;
    logic [3:0]  r_cnt;
    logic [15:0] r_adr;
    logic [31:0] r_wdata;
    logic [31:0] r_dat;
    logic        r_ack;
    logic [15:0] r_err_cnt;
`ifdef WB_DEC_CTRL_ERR_EN
    logic        r_err;
`endif

    logic        w_hit;

    assign w_hit = |dec_sel_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= c_idle;
            r_we      <= 1'b0;
            r_cnt     <= 4'd0;
            r_adr     <= 16'h0;
            r_wdata   <= 32'h0;
            r_dat     <= 32'h0;
            r_ack     <= 1'b0;
            r_err_cnt <= 16'h0;
`ifdef WB_DEC_CTRL_ERR_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef WB_DEC_CTRL_ERR_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                c_idle: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        r_adr   <= wb_adr_i;
                        r_wdata <= wb_dat_i;
                        r_we    <= wb_we_i;
                        r_state <= c_decode;
                    end
                end
                c_decode: begin
                    if (!wb_cyc_i) begin
                        r_state <= c_idle;
                    end else if (!w_hit) begin
                        if (r_err_cnt != 16'hFFFF) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
`ifdef WB_DEC_CTRL_ERR_EN
                        r_err <= 1'b1;
`else
                        // Unmapped reads complete normally but return zero.
                        r_ack <= 1'b1;
                        if (!r_we) begin
                            r_dat <= 32'h0;
                        end
`endif
                        r_state <= c_ack;
                    end else if (r_we) begin
                        r_ack   <= 1'b1;
                        r_state <= c_ack;
                    end else if (RD_WAIT == 0) begin
                        r_dat   <= dec_data_i;
                        r_ack   <= 1'b1;
                        r_state <= c_ack;
                    end else begin
                        r_cnt   <= c_wait_load;
                        r_state <= c_wait;
                    end
                end
                c_wait: begin
                    if (!wb_cyc_i) begin
                        r_state <= c_idle;
                    end else if (r_cnt == 4'd0) begin
                        r_dat   <= dec_data_i;
                        r_ack   <= 1'b1;
                        r_state <= c_ack;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ack: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Strobe is combinational so it lines up with the decoder's view of r_adr.
    assign reg_wr_o    = (r_state == c_decode && r_we && wb_cyc_i) ? dec_sel_i : 16'h0;
    assign wb_dat_o    = r_dat;
    assign wb_ack_o    = r_ack;
`ifdef WB_DEC_CTRL_ERR_EN
    assign wb_err_o    = r_err;
`else
    assign wb_err_o    = 1'b0;
`endif
    assign dec_addr_o  = r_adr;
    assign reg_wdata_o = r_wdata;
    assign err_cnt_o   = r_err_cnt;
    assign busy_o      = (r_state != c_idle);

endmodule
`default_nettype wire
